// File: rtl/jtag_cmd_chain_if.sv
// System-side command/read-return bundle for jtag_cmd_chain.
// The master drives commands out and accepts returned read words.
interface jtag_cmd_chain_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BE_WIDTH    = 4,
  parameter int BURST_WIDTH = 8
);
  logic                   cmd_valid;
  logic                   cmd_write;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [BE_WIDTH-1:0]    cmd_be;
  logic [BURST_WIDTH-1:0] cmd_burst;
  logic [DATA_WIDTH-1:0]  cmd_wdata;
  logic                   cmd_ready;
  logic                   rd_valid;
  logic [DATA_WIDTH-1:0]  rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_burst, cmd_wdata,
    input  cmd_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_burst, cmd_wdata,
    output cmd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/jtag_cmd_chain.sv
// JTAG user data register that configures and issues system commands and
// buffers returned read words; everything runs on JTCK.
module jtag_cmd_chain #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int BE_WIDTH    = 4,
  parameter int BURST_WIDTH = 8,
  parameter int BUF_DEPTH   = 8,
  parameter int AUTO_INC    = 1
) (
  input  logic JTCK,
  input  logic JRSTN,
  input  logic JTDI,
  input  logic JSHIFT,
  input  logic JUPDATE,
  input  logic JCE,
  input  logic JRTI,
  output logic JTDO,
  jtag_cmd_chain_if.master sys
);

  localparam int SCAN_W = DATA_WIDTH + OP_WIDTH;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [OP_WIDTH-1:0] OP_NOP       = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_WR_ADDR   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_WR_BE     = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_WR_BURST  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_RD_ADDR   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_RD_BE     = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_RD_BURST  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_RD_STATUS = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_WR_DATA   = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_RD_MEM    = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_RD_BUF    = OP_WIDTH'(10);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ISSUE} state_t;

  state_t                 state_q, state_d;
  logic [SCAN_W-1:0]      scan_q, scan_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BE_WIDTH-1:0]    be_q, be_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  cap_q, cap_d;
  logic                   upd_q, upd_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic                   req_write_q, req_write_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
  logic [BE_WIDTH-1:0]    cmd_be_q, cmd_be_d;
  logic [BURST_WIDTH-1:0] cmd_burst_q, cmd_burst_d;
  logic [DATA_WIDTH-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]  mem [BUF_DEPTH];

  logic                   upd_fire;
  logic [OP_WIDTH-1:0]    op;
  logic [DATA_WIDTH-1:0]  pl;
  logic [OP_WIDTH-1:0]    status;
  logic                   busy, not_empty, full;
  logic                   req, req_wr, pop_req, do_pop, do_push;
  logic                   err_set, ovf_set, flags_clr;

  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    addr_d      = addr_q;
    be_d        = be_q;
    burst_d     = burst_q;
    wdata_d     = wdata_q;
    cap_d       = cap_q;
    upd_d       = JUPDATE;
    err_d       = err_q;
    ovf_d       = ovf_q;
    req_write_d = req_write_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_be_d    = cmd_be_q;
    cmd_burst_d = cmd_burst_q;
    cmd_wdata_d = cmd_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    req         = 1'b0;
    req_wr      = 1'b0;
    pop_req     = 1'b0;
    err_set     = 1'b0;
    ovf_set     = 1'b0;
    flags_clr   = 1'b0;

    upd_fire  = JUPDATE & ~upd_q;
    op        = scan_q[OP_WIDTH-1:0];
    pl        = scan_q[SCAN_W-1:OP_WIDTH];
    busy      = (state_q != ST_IDLE);
    not_empty = (cnt_q != '0);
    full      = (cnt_q == CNT_W'(BUF_DEPTH));

    status    = '0;
    status[0] = busy;
    status[1] = not_empty;
    status[2] = err_q;
    status[3] = ovf_q;

    if (JCE) begin
      if (JSHIFT) scan_d = {JTDI, scan_q[SCAN_W-1:1]};
      else        scan_d = {cap_q, status};
    end

    // Auto-increment goes first so an explicit address write in the same cycle wins.
    if (state_q == ST_ISSUE && sys.cmd_ready && cmd_write_q && AUTO_INC != 0)
      addr_d = addr_q + ADDR_WIDTH'(BE_WIDTH);

    if (upd_fire) begin
      case (op)
        OP_NOP:       cap_d   = '0;
        OP_WR_ADDR:   addr_d  = ADDR_WIDTH'(pl);
        OP_WR_BE:     be_d    = BE_WIDTH'(pl);
        OP_WR_BURST:  burst_d = BURST_WIDTH'(pl);
        OP_RD_ADDR:   cap_d   = DATA_WIDTH'(addr_q);
        OP_RD_BE:     cap_d   = DATA_WIDTH'(be_q);
        OP_RD_BURST:  cap_d   = DATA_WIDTH'(burst_q);
        OP_RD_STATUS: begin
          cap_d     = DATA_WIDTH'({ovf_q, err_q, not_empty, busy, cnt_q});
          flags_clr = 1'b1;
        end
        OP_WR_DATA: begin
          wdata_d = pl;
          req     = 1'b1;
          req_wr  = 1'b1;
        end
        OP_RD_MEM:    req     = 1'b1;
        OP_RD_BUF: begin
          pop_req = 1'b1;
          cap_d   = not_empty ? mem[rd_ptr_q] : '0;
        end
        default:      err_set = 1'b1;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d     = ST_PEND;
          req_write_d = req_wr;
        end
      end
      ST_PEND: begin
        if (JRTI) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_write_d = req_write_q;
          cmd_addr_d  = addr_q;
          cmd_be_d    = be_q;
          cmd_burst_d = burst_q;
          cmd_wdata_d = wdata_q;
        end
      end
      ST_ISSUE: begin
        if (sys.cmd_ready) begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (req && busy) err_set = 1'b1;

    // A pop frees a slot in the same cycle, so a push into a full buffer still lands.
    do_pop  = pop_req & not_empty;
    do_push = sys.rd_valid & (~full | do_pop);
    if (pop_req && !not_empty) err_set = 1'b1;
    if (sys.rd_valid && !do_push) ovf_set = 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);

    if (flags_clr) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (err_set) err_d = 1'b1;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      state_q     <= ST_IDLE;
      scan_q      <= '0;
      addr_q      <= '0;
      be_q        <= '1;
      burst_q     <= '0;
      wdata_q     <= '0;
      cap_q       <= '0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      req_write_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_be_q    <= '0;
      cmd_burst_q <= '0;
      cmd_wdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      burst_q     <= burst_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      req_write_q <= req_write_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_be_q    <= cmd_be_d;
      cmd_burst_q <= cmd_burst_d;
      cmd_wdata_q <= cmd_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Buffer storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge JTCK) begin
    if (do_push) mem[wr_ptr_q] <= sys.rd_data;
  end

  assign JTDO          = scan_q[0];
  assign sys.cmd_valid = cmd_valid_q;
  assign sys.cmd_write = cmd_write_q;
  assign sys.cmd_addr  = cmd_addr_q;
  assign sys.cmd_be    = cmd_be_q;
  assign sys.cmd_burst = cmd_burst_q;
  assign sys.cmd_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_jtag_cmd_chain.sv
// Directed bench for jtag_cmd_chain: scans 36-bit words through the chain
// and checks shifted-out capture words and the command interface.
module tb_jtag_cmd_chain;
  logic JTCK, JRSTN, JTDI, JSHIFT, JUPDATE, JCE, JRTI, JTDO;
  logic [35:0] so;
  int checks = 0;
  int errors = 0;

  jtag_cmd_chain_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BE_WIDTH(4), .BURST_WIDTH(8)) sys_if ();

  jtag_cmd_chain dut (
    .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT),
    .JUPDATE(JUPDATE), .JCE(JCE), .JRTI(JRTI), .JTDO(JTDO), .sys(sys_if.master)
  );

  initial JTCK = 1'b0;
  always #5 JTCK = ~JTCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One capture, 36 shifts (LSB first), one update pulse; returns the captured word.
  task automatic scan(input logic [31:0] pl, input logic [3:0] op, output logic [35:0] dout);
    logic [35:0] din;
    din = {pl, op};
    @(negedge JTCK); JCE = 1'b1; JSHIFT = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge JTCK); JSHIFT = 1'b1; dout[i] = JTDO; JTDI = din[i];
    end
    @(negedge JTCK); JCE = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b1;
    @(negedge JTCK); JUPDATE = 1'b0;
    $display("scan op=%h pl=%h -> out=%h", op, pl, dout);
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge JTCK); sys_if.rd_valid = 1'b1; sys_if.rd_data = base + 32'(i);
    end
    @(negedge JTCK); sys_if.rd_valid = 1'b0;
    $display("pushed %0d words from %h", n, base);
  endtask

  initial begin
    JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JCE = 1'b0; JRTI = 1'b0;
    sys_if.cmd_ready = 1'b0; sys_if.rd_valid = 1'b0; sys_if.rd_data = '0;
    repeat (2) @(negedge JTCK);
    chk("rst_jtdo", 64'(JTDO), 64'd0);
    chk("rst_cmd_valid", 64'(sys_if.cmd_valid), 64'd0);
    JRSTN = 1'b1;

    // Address register write and readback
    scan(32'h5555_5555, 4'h1, so); chk("cap_after_reset", 64'(so), 64'h0);
    scan(32'h0, 4'h0, so);         chk("cap_idle_status", 64'(so), 64'h0);
    scan(32'h0, 4'h4, so);         chk("rd_addr_pre", 64'(so), 64'h0);
    scan(32'h0, 4'h0, so);         chk("rd_addr", 64'(so), {32'h5555_5555, 4'h0});

    // Byte-enable truncation
    scan(32'hE2, 4'h2, so);        chk("wr_be", 64'(so), 64'h0);
    scan(32'h0, 4'h5, so);         chk("rd_be_pre", 64'(so), 64'h0);
    scan(32'h0, 4'h0, so);         chk("rd_be", 64'(so), {32'h2, 4'h0});

    // Write command with stalled ready, dropped second request, auto-increment
    scan(32'h100, 4'h1, so);       chk("wr_addr100", 64'(so), 64'h0);
    scan(32'h3, 4'h3, so);         chk("wr_burst", 64'(so), 64'h0);
    JRTI = 1'b1;
    scan(32'hDEAD_BEEF, 4'h8, so); chk("wr_data", 64'(so), 64'h0);
    chk("wr_pend_valid", 64'(sys_if.cmd_valid), 64'd0);
    @(negedge JTCK);
    chk("wr_valid", 64'(sys_if.cmd_valid), 64'd1);
    chk("wr_write", 64'(sys_if.cmd_write), 64'd1);
    chk("wr_addr", 64'(sys_if.cmd_addr), 64'h100);
    chk("wr_be_f", 64'(sys_if.cmd_be), 64'h2);
    chk("wr_burst_f", 64'(sys_if.cmd_burst), 64'h3);
    chk("wr_wdata", 64'(sys_if.cmd_wdata), 64'hDEAD_BEEF);
    repeat (2) begin
      @(negedge JTCK); chk("wr_hold_valid", 64'(sys_if.cmd_valid), 64'd1);
    end
    scan(32'h1234_5678, 4'h8, so); chk("busy_status", 64'(so), {32'h0, 4'h1});
    chk("drop_valid", 64'(sys_if.cmd_valid), 64'd1);
    chk("drop_wdata", 64'(sys_if.cmd_wdata), 64'hDEAD_BEEF);
    chk("drop_addr", 64'(sys_if.cmd_addr), 64'h100);
    sys_if.cmd_ready = 1'b1;
    @(negedge JTCK); chk("wr_accept", 64'(sys_if.cmd_valid), 64'd0);
    sys_if.cmd_ready = 1'b0;
    scan(32'h0, 4'h4, so);         chk("err_status", 64'(so), {32'h0, 4'h4});
    scan(32'h0, 4'h0, so);         chk("auto_inc", 64'(so), {32'h104, 4'h4});

    // Read command waits for JRTI
    JRTI = 1'b0;
    scan(32'h0, 4'h9, so);         chk("rd_mem", 64'(so), {32'h0, 4'h4});
    repeat (2) begin
      @(negedge JTCK); chk("rd_wait_rti", 64'(sys_if.cmd_valid), 64'd0);
    end
    JRTI = 1'b1;
    @(negedge JTCK);
    chk("rd_valid", 64'(sys_if.cmd_valid), 64'd1);
    chk("rd_write", 64'(sys_if.cmd_write), 64'd0);
    chk("rd_addr_f", 64'(sys_if.cmd_addr), 64'h104);
    chk("rd_burst_f", 64'(sys_if.cmd_burst), 64'h3);
    sys_if.cmd_ready = 1'b1;
    @(negedge JTCK); chk("rd_accept", 64'(sys_if.cmd_valid), 64'd0);
    sys_if.cmd_ready = 1'b0; JRTI = 1'b0;
    scan(32'h0, 4'h4, so);         chk("no_inc_rd_pre", 64'(so), {32'h0, 4'h4});
    scan(32'h0, 4'h0, so);         chk("no_inc_rd", 64'(so), {32'h104, 4'h4});

    // Read buffer fill and drain, then underflow
    push_words(32'hA0, 4);
    scan(32'h0, 4'h7, so);         chk("status4_pre", 64'(so), {32'h0, 4'h6});
    scan(32'h0, 4'hA, so);         chk("status4", 64'(so), {32'h64, 4'h2});
    scan(32'h0, 4'hA, so);         chk("pop_a0", 64'(so), {32'hA0, 4'h2});
    scan(32'h0, 4'hA, so);         chk("pop_a1", 64'(so), {32'hA1, 4'h2});
    scan(32'h0, 4'hA, so);         chk("pop_a2", 64'(so), {32'hA2, 4'h2});
    scan(32'h0, 4'hA, so);         chk("pop_a3", 64'(so), {32'hA3, 4'h0});
    scan(32'h0, 4'h0, so);         chk("pop_empty", 64'(so), {32'h0, 4'h4});

    // Overflow: nine pushes into eight slots
    push_words(32'hB0, 9);
    scan(32'h0, 4'h7, so);         chk("ovf_status_pre", 64'(so), {32'h0, 4'hE});
    scan(32'h0, 4'h7, so);         chk("ovf_status", 64'(so), {32'hE8, 4'h2});
    scan(32'h0, 4'h0, so);         chk("ovf_cleared", 64'(so), {32'h28, 4'h2});
    for (int k = 0; k < 9; k++) begin
      logic [35:0] exp_w;
      if (k == 0)      exp_w = {32'h0, 4'h2};
      else if (k < 8)  exp_w = {32'hB0 + 32'(k - 1), 4'h2};
      else             exp_w = {32'hB7, 4'h0};
      scan(32'h0, 4'hA, so);       chk("drain_b", 64'(so), 64'(exp_w));
    end
    scan(32'h0, 4'h0, so);         chk("drain_under", 64'(so), {32'h0, 4'h4});

    // Asynchronous reset during an issued command with two buffered words
    push_words(32'hC0, 2);
    JRTI = 1'b1;
    scan(32'h0, 4'h9, so);         chk("pre_rst_status", 64'(so), {32'h0, 4'h6});
    @(negedge JTCK); chk("pre_rst_valid", 64'(sys_if.cmd_valid), 64'd1);
    #2 JRSTN = 1'b0;
    #1 chk("async_valid", 64'(sys_if.cmd_valid), 64'd0);
    @(negedge JTCK); JRSTN = 1'b1; JRTI = 1'b0;
    scan(32'h0, 4'h7, so);         chk("post_rst_status", 64'(so), 64'h0);
    scan(32'h0, 4'h0, so);         chk("post_rst_fill", 64'(so), 64'h0);
    scan(32'h0, 4'h5, so);         chk("post_rst_be_pre", 64'(so), 64'h0);
    scan(32'h0, 4'h0, so);         chk("post_rst_be", 64'(so), {32'hF, 4'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_cmd_chain.md
Name: jtag_cmd_chain

Overview:
Parametrised successor to the fixed 36-bit JTAG user chain. It is driven by the JTAGG primitive's user-chain strobes and clocked entirely on JTCK. Scan words carry an opcode plus payload and configure address, byte-enable and burst registers. It issues write/read commands to the system side over a valid/ready handshake and buffers returned read words in a FIFO that JTAG drains. Status is returned on every capture; clock-domain crossing is handled outside this block.

Parameters:
DATA_WIDTH, 32, payload width; scan register length is DATA_WIDTH+OP_WIDTH
OP_WIDTH, 4, opcode width (>=4)
ADDR_WIDTH, 32, address register width (<=DATA_WIDTH)
BE_WIDTH, 4, byte-enable width
BURST_WIDTH, 8, burst register width
BUF_DEPTH, 8, read-buffer depth in words (power of 2, >=2)
AUTO_INC, 1, 1 = address += BE_WIDTH after each accepted write command

Ports:
JTCK  in  1  JTAG clock; all state on rising edge
JRSTN  in  1  asynchronous active-low reset
JTDI  in  1  serial data in
JSHIFT  in  1  shift-DR strobe
JUPDATE  in  1  update-DR strobe
JCE  in  1  chain enable (capture/shift)
JRTI  in  1  run-test-idle for this chain
JTDO  out  1  serial data out = scan[0]
cmd_valid  out  1  command pending to system
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  ADDR_WIDTH  command address
cmd_be  out  BE_WIDTH  command byte enables
cmd_burst  out  BURST_WIDTH  command burst length
cmd_wdata  out  DATA_WIDTH  write data
cmd_ready  in  1  system accepts command
rd_valid  in  1  read word present on rd_data
rd_data  in  DATA_WIDTH  returned read word

Behaviour:
- Reset (JRSTN low, async): scan, addr, be, burst, wdata, capture_data, FIFO pointers/count, sticky flags, upd_q = 0; be = all-ones; cmd_valid = 0; FSM = IDLE. Mid-transfer reset drops the pending command and flushes the FIFO.
- Capture: when JCE=1 and JSHIFT=0, load scan <= {capture_data, status}. Status is OP_WIDTH bits: [0] busy (FSM != IDLE), [1] FIFO not empty, [2] error, [3] overflow; upper bits 0.
- Shift: when JCE=1 and JSHIFT=1, scan <= {JTDI, scan[top:1]}. Data enters LSB-first.
- Update: fires once per JUPDATE rising edge (JUPDATE & ~upd_q). Decoded fields: op = scan[OP_WIDTH-1:0], pl = scan[top:OP_WIDTH].
- Opcodes:
  - 0 NOP: capture_data <= 0.
  - 1/2/3: addr/be/burst <= pl truncated.
  - 4/5/6: capture_data <= addr/be/burst, zero-extended.
  - 7 RD_STATUS: capture_data <= {0, ovf, err, not_empty, busy, fill_count}. Clears err and ovf after the load (read-to-clear).
  - 8 WR_DATA: wdata <= pl; request write.
  - 9 RD_MEM: request read.
  - A RD_BUF: pop the FIFO head into capture_data. If empty: capture_data <= 0, err <= 1.
  - Others: err <= 1, no other effect.
- Command FSM:
  - IDLE -> PEND on a request.
  - PEND -> ISSUE on the first cycle JRTI=1: cmd_valid <= 1 with fields latched from the registers.
  - ISSUE -> IDLE on the cycle cmd_valid & cmd_ready: cmd_valid <= 0. On a write with AUTO_INC, addr += BE_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - A request while not IDLE is dropped and sets err. Command fields stay stable while cmd_valid is high.
- FIFO:
  - Push on rd_valid; pop on RD_BUF.
  - Push when full: word dropped, ovf <= 1, unless a pop occurs in the same cycle (both proceed, count unchanged).
  - Pop and push when empty in the same cycle: pop underflows (err), push succeeds.
  - Pointers wrap modulo BUF_DEPTH.
- Latency: update to cmd_valid is 1 cycle if JRTI is already high.

Test Plan:
- Reset, then shift 36'h5555_5555_1, pulse JUPDATE -> addr = 32'h5555_5555; next capture with no request shifts status 4'b0000 and data 0 out of JTDO.
- WR_BE pl=0xE2 then RD_BE, recapture -> shifted-out word = {32'h0000_0002, 4'b0000} (BE_WIDTH=4 truncates to 4'h2).
- addr=0x100, WR_DATA 0xDEADBEEF with JRTI=1, cmd_ready held low 3 cycles -> cmd_valid high 4 cycles, fields stable. Second WR_DATA during ISSUE -> dropped, err=1. After accept, addr = 0x104.
- RD_MEM burst=3, system pushes 4 words 0xA0..0xA3 -> four RD_BUF ops return 0xA0, 0xA1, 0xA2, 0xA3. Fifth RD_BUF -> data 0, err=1.
- Push 9 words with BUF_DEPTH=8 -> ovf=1, 9th dropped. RD_STATUS returns fill 8 with ovf and err set; second RD_STATUS shows both cleared.
- JRSTN pulsed low during ISSUE with FIFO holding 2 words -> cmd_valid falls asynchronously, fill 0, FSM IDLE.
